// File: rtl/div_unit_pkg.sv
// Shared types and encodings for the iterative divider
// and its issue/write-back neighbours.
package div_unit_pkg;

  localparam int REG_WIDTH = 5;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef struct packed {
    logic [1:0]           div_control;
    logic [REG_WIDTH-1:0] rd;
    logic [31:0]          rs1;
    logic [31:0]          rs2;
  } ix_div_inf_t;

  typedef struct packed {
    logic [REG_WIDTH-1:0] rd;
    logic [31:0]          result;
  } div_wb_inf_t;

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider, one quotient bit per cycle.
// Div-by-zero and signed overflow bypass the iteration.
import div_unit_pkg::*;

module div_unit #(
  parameter int DIV_WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ix_div_valid,
  input  ix_div_inf_t ix_div_inf,
  input  logic        wb_do_branch,
  output logic        div_ix_done,
  output logic        div_wb_valid,
  output div_wb_inf_t div_wb_inf
);

  localparam int W  = DIV_WIDTH;
  localparam int CW = $clog2(DIV_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [W-1:0]         dvd_q, dvd_d;
  logic [W-1:0]         dvs_q, dvs_d;
  logic [W-1:0]         rem_q, rem_d;
  logic [W-1:0]         quot_q, quot_d;
  logic [REG_WIDTH-1:0] rd_q, rd_d;
  logic                 is_rem_q, is_rem_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic                 pulse_q, pulse_d;
  div_wb_inf_t          wb_q, wb_d;

  logic         op_signed;
  logic         op_rem;
  logic [31:0]  a_raw;
  logic [31:0]  b_raw;
  logic [W-1:0] a_mag;
  logic [W-1:0] b_mag;
  logic         div_zero;
  logic         ovf;

  assign op_signed = ~ix_div_inf.div_control[0];
  assign op_rem    = ix_div_inf.div_control[1];
  assign a_raw     = ix_div_inf.rs1;
  assign b_raw     = ix_div_inf.rs2;
  assign a_mag     = (op_signed && a_raw[31]) ? -a_raw : a_raw;
  assign b_mag     = (op_signed && b_raw[31]) ? -b_raw : b_raw;
  assign div_zero  = (b_raw == '0);
  assign ovf       = op_signed
                   && (a_raw == 32'h8000_0000)
                   && (b_raw == 32'hFFFF_FFFF);

  // One restoring step: trial-subtract on a W+1 bit window
  logic [W:0]   rem_sh;
  logic [W:0]   diff;
  logic         qbit;
  logic [W-1:0] rem_nx;
  logic [W-1:0] quot_nx;
  logic [W-1:0] q_fin;
  logic [W-1:0] r_fin;

  assign rem_sh  = {rem_q, dvd_q[W-1]};
  assign diff    = rem_sh - {1'b0, dvs_q};
  assign qbit    = ~diff[W];
  assign rem_nx  = qbit ? diff[W-1:0] : rem_sh[W-1:0];
  assign quot_nx = {quot_q[W-2:0], qbit};
  assign q_fin   = q_neg_q ? -quot_nx : quot_nx;
  assign r_fin   = r_neg_q ? -rem_nx : rem_nx;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    dvd_d    = dvd_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    rd_d     = rd_q;
    is_rem_d = is_rem_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    pulse_d  = 1'b0;
    wb_d     = wb_q;
    unique case (state_q)
      S_IDLE: begin
        if (ix_div_valid && !wb_do_branch) begin
          rd_d     = ix_div_inf.rd;
          is_rem_d = op_rem;
          q_neg_d  = op_signed & (a_raw[31] ^ b_raw[31]);
          r_neg_d  = op_signed & a_raw[31];
          dvd_d    = a_mag;
          dvs_d    = b_mag;
          rem_d    = '0;
          quot_d   = '0;
          count_d  = CW'(W - 1);
          if (div_zero) begin
            wb_d.rd     = ix_div_inf.rd;
            wb_d.result = op_rem ? a_raw : 32'hFFFF_FFFF;
            pulse_d     = 1'b1;
            state_d     = S_DONE;
          end else if (ovf) begin
            wb_d.rd     = ix_div_inf.rd;
            wb_d.result = op_rem ? 32'h0 : 32'h8000_0000;
            pulse_d     = 1'b1;
            state_d     = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (wb_do_branch) begin
          state_d = S_IDLE;
        end else begin
          dvd_d   = {dvd_q[W-2:0], 1'b0};
          rem_d   = rem_nx;
          quot_d  = quot_nx;
          count_d = count_q - 1'b1;
          if (count_q == '0) begin
            count_d     = '0;
            wb_d.rd     = rd_q;
            wb_d.result = is_rem_q ? r_fin : q_fin;
            pulse_d     = 1'b1;
            state_d     = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      rd_q     <= '0;
      is_rem_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      pulse_q  <= 1'b0;
      wb_q     <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      dvd_q    <= dvd_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      rd_q     <= rd_d;
      is_rem_q <= is_rem_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      pulse_q  <= pulse_d;
      wb_q     <= wb_d;
    end
  end

  // A flush or reset landing in DONE must still kill the pulse
  assign div_wb_valid = pulse_q & ~wb_do_branch & ~rst;
  assign div_ix_done  = pulse_q & ~wb_do_branch & ~rst;
  assign div_wb_inf   = wb_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed ops, flush,
// reset and ignored-valid cases with cycle-exact latency.
module tb_div_unit;
  import div_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ix_div_valid = 1'b0;
  logic        wb_do_branch = 1'b0;
  ix_div_inf_t ix_div_inf = '0;
  logic        div_ix_done;
  logic        div_wb_valid;
  div_wb_inf_t div_wb_inf;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .ix_div_valid (ix_div_valid),
    .ix_div_inf   (ix_div_inf),
    .wb_do_branch (wb_do_branch),
    .div_ix_done  (div_ix_done),
    .div_wb_valid (div_wb_valid),
    .div_wb_inf   (div_wb_inf)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] res;
    int          at;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  div_wb_inf_t last_wb = '0;

  task automatic chk(string name, logic [63:0] act,
                     logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (div_wb_valid || div_ix_done)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse",
            {62'd0, div_wb_valid, div_ix_done}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("pulse_pair",
            {62'd0, div_wb_valid, div_ix_done}, 64'd3);
        chk("rd", div_wb_inf.rd, e.rd);
        chk("result", div_wb_inf.result, e.res);
        chk("cycle", cyc, e.at);
        last_wb = {e.rd, e.res};
      end
    end
  end

  // Called at a negedge (cycle 0); returns at the next negedge.
  task automatic issue(logic [1:0] ctl, logic [4:0] rd,
                       logic [31:0] a, logic [31:0] b,
                       logic [31:0] res, int lat, bit exp_it);
    ix_div_valid = 1'b1;
    ix_div_inf   = {ctl, rd, a, b};
    if (exp_it) sb.push_back('{rd, res, cyc + lat});
    @(negedge clk);
    ix_div_valid = 1'b0;
  endtask

  // Issue and then wait until the unit is idle again.
  task automatic run(logic [1:0] ctl, logic [4:0] rd,
                     logic [31:0] a, logic [31:0] b,
                     logic [31:0] res, int lat);
    issue(ctl, rd, a, b, res, lat, 1'b1);
    repeat (lat) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", {63'd0, div_wb_valid}, 64'd0);
    chk("rst_done", {63'd0, div_ix_done}, 64'd0);
    chk("rst_inf", div_wb_inf, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run(DIV_OP_DIV,  5'd5, 32'd100, 32'd7, 32'd14, 33);
    run(DIV_OP_REM,  5'd1, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFF, 33);
    run(DIV_OP_DIV,  5'd2, 32'hFFFF_FFF9, 32'd2,
        32'hFFFF_FFFD, 33);
    run(DIV_OP_DIVU, 5'd3, 32'hFFFF_FFFF, 32'd1,
        32'hFFFF_FFFF, 33);
    run(DIV_OP_DIV,  5'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run(DIV_OP_REMU, 5'd6, 32'd5, 32'd0, 32'd5, 1);
    run(DIV_OP_DIV,  5'd7, 32'h8000_0000, 32'hFFFF_FFFF,
        32'h8000_0000, 1);
    run(DIV_OP_REM,  5'd8, 32'h8000_0000, 32'hFFFF_FFFF,
        32'd0, 1);
    run(DIV_OP_REM,  5'd9, 32'hFFFF_FFF9, 32'd0,
        32'hFFFF_FFF9, 1);
    run(DIV_OP_DIVU, 5'd10, 32'h8000_0000, 32'hFFFF_FFFF,
        32'd0, 33);
    run(DIV_OP_DIV,  5'd11, 32'd20, 32'hFFFF_FFFD,
        32'hFFFF_FFFA, 33);
    run(DIV_OP_REM,  5'd12, 32'd20, 32'hFFFF_FFFD, 32'd2, 33);
    run(DIV_OP_DIVU, 5'd13, 32'hFFFF_FFFF, 32'h10,
        32'h0FFF_FFFF, 33);
    run(DIV_OP_REMU, 5'd14, 32'hFFFF_FFFF, 32'h10, 32'hF, 33);
    run(DIV_OP_DIV,  5'd15, 32'h8000_0000, 32'd2,
        32'hC000_0000, 33);
    run(DIV_OP_REMU, 5'd0, 32'd100, 32'd7, 32'd2, 33);

    repeat (5) @(negedge clk);
    chk("hold_inf", div_wb_inf, last_wb);

    // Flush in cycle 10 kills the op; next op accepted cycle 11
    issue(DIV_OP_DIV, 5'd5, 32'd100, 32'd7, 32'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    wb_do_branch = 1'b1;
    @(negedge clk);
    wb_do_branch = 1'b0;
    run(DIV_OP_DIVU, 5'd16, 32'd9, 32'd3, 32'd3, 33);

    // Valid together with flush is dropped
    ix_div_valid = 1'b1;
    wb_do_branch = 1'b1;
    ix_div_inf   = {DIV_OP_DIV, 5'd17, 32'd50, 32'd5};
    @(negedge clk);
    ix_div_valid = 1'b0;
    wb_do_branch = 1'b0;
    run(DIV_OP_DIV, 5'd18, 32'd49, 32'd7, 32'd7, 33);

    // Valid during CALC is ignored
    issue(DIV_OP_DIVU, 5'd19, 32'd1000, 32'd10, 32'd100,
          33, 1'b1);
    repeat (4) @(negedge clk);
    ix_div_valid = 1'b1;
    ix_div_inf   = {DIV_OP_DIV, 5'd20, 32'd8, 32'd2};
    @(negedge clk);
    ix_div_valid = 1'b0;
    repeat (28) @(negedge clk);

    // Reset mid-op abandons it and clears the result bus
    issue(DIV_OP_DIV, 5'd21, 32'd77, 32'd7, 32'd0, 0, 1'b0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_inf", div_wb_inf, 64'd0);
    run(DIV_OP_DIV, 5'd22, 32'd77, 32'd7, 32'd11, 33);

    repeat (40) @(negedge clk);
    for (int i = 0; i < 200 && sb.size() != 0; i++)
      @(negedge clk);
    chk("drain", sb.size(), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
